// File: rtl/record_pkg.sv
// Shared definitions for the record sequencer: opcodes, FSM state type and
// the default record geometry.
package record_pkg;

    localparam int WORD_SIZE    = 8;
    localparam int RECORD_WORDS = 16;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOVE = 8'h01;
    localparam logic [7:0] OP_STOP = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_HALTED
    } seq_state_t;

endpackage

// File: rtl/record_sequencer_if.sv
// FIFO read port and segment handshake of the record sequencer, bundled.
// master = sequencer side, slave = FIFO/step-engine side.
interface record_sequencer_if
    import record_pkg::*;
#(
    parameter int WordSize    = WORD_SIZE,
    parameter int RecordWords = RECORD_WORDS
);
    logic                                  fifo_empty;
    logic [WordSize*RecordWords-1:0]       fifo_data;
    logic                                  fifo_read_en;
    logic                                  seg_valid;
    logic                                  seg_ready;
    logic [WordSize*(RecordWords-1)-1:0]   seg_data;

    modport master (
        input  fifo_empty, fifo_data, seg_ready,
        output fifo_read_en, seg_valid, seg_data
    );

    modport slave (
        output fifo_empty, fifo_data, seg_ready,
        input  fifo_read_en, seg_valid, seg_data
    );
endinterface

// File: rtl/record_decoder.sv
// Combinational opcode classifier for one latched record. With
// RECORD_CHECKSUM_EN defined it also reports whether all words XOR to zero.
module record_decoder
    import record_pkg::*;
#(
    parameter int WordSize    = WORD_SIZE,
    parameter int RecordWords = RECORD_WORDS
) (
    input  logic [WordSize*RecordWords-1:0] rec,
    output logic                            is_nop,
    output logic                            is_move,
    output logic                            is_stop,
    output logic                            is_bad
`ifdef RECORD_CHECKSUM_EN
    ,
    output logic                            checksum_ok
`endif
);
    logic [WordSize-1:0] opcode;

    assign opcode  = rec[WordSize-1:0];
    assign is_nop  = (opcode == WordSize'(OP_NOP));
    assign is_move = (opcode == WordSize'(OP_MOVE));
    assign is_stop = (opcode == WordSize'(OP_STOP));
    assign is_bad  = !(is_nop || is_move || is_stop);

`ifdef RECORD_CHECKSUM_EN
    // Running XOR across the words; the last stage is the whole-record parity.
    logic [WordSize-1:0] xor_chain [RecordWords+1];
    assign xor_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < RecordWords; gi++) begin : g_xor
            assign xor_chain[gi+1] = xor_chain[gi] ^ rec[gi*WordSize +: WordSize];
        end
    endgenerate

    assign checksum_ok = (xor_chain[RecordWords] == '0);
`else
    logic unused_payload;
    assign unused_payload = ^rec[WordSize*RecordWords-1:WordSize];
`endif

endmodule

// File: rtl/record_sequencer.sv
// Read-side controller of the byte-to-record FIFO: fetches one record at a time,
// decodes it and forwards MOVE payloads. Optional RECORD_CHECKSUM_EN adds a record XOR check.
module record_sequencer
    import record_pkg::*;
#(
    parameter int WordSize    = WORD_SIZE,
    parameter int RecordWords = RECORD_WORDS,
    parameter int CountWidth  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  resume,
    record_sequencer_if.master    bus,
    output logic                  halted,
    output logic                  error,
    output logic [CountWidth-1:0] rec_count
);
    localparam int RecBits = WordSize * RecordWords;

    seq_state_t              state_q, state_d;
    logic [RecBits-1:0]      rec_q, rec_d;
    logic [CountWidth-1:0]   count_q, count_d;
    logic                    error_q, error_d;
    logic                    read_en;
    logic                    seg_valid;

    logic is_nop, is_move, is_stop, is_bad;
`ifdef RECORD_CHECKSUM_EN
    logic checksum_ok;
`endif

    record_decoder #(
        .WordSize    (WordSize),
        .RecordWords (RecordWords)
    ) u_decoder (
        .rec         (rec_q),
        .is_nop      (is_nop),
        .is_move     (is_move),
        .is_stop     (is_stop),
        .is_bad      (is_bad)
`ifdef RECORD_CHECKSUM_EN
        ,
        .checksum_ok (checksum_ok)
`endif
    );

    always_comb begin
        state_d   = state_q;
        rec_d     = rec_q;
        count_d   = count_q;
        error_d   = error_q;
        read_en   = 1'b0;
        seg_valid = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // FIFO data is only valid up to the dequeue edge, so capture now.
                if (enable && !bus.fifo_empty) begin
                    read_en = 1'b1;
                    rec_d   = bus.fifo_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
`ifdef RECORD_CHECKSUM_EN
                if (!checksum_ok) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else
`endif
                if (is_nop) begin
                    count_d = count_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (is_move) begin
                    state_d = ST_ISSUE;
                end else if (is_stop) begin
                    count_d = count_q + 1'b1;
                    state_d = ST_HALTED;
                end else if (is_bad) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                seg_valid = 1'b1;
                if (bus.seg_ready) begin
                    count_d = count_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rec_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign bus.fifo_read_en = read_en && !rst;
    assign bus.seg_valid    = seg_valid;
    // Payload is zeroed outside ISSUE so nothing stale is visible downstream.
    assign bus.seg_data     = seg_valid ? rec_q[RecBits-1:WordSize] : '0;
    assign error            = error_q;
    assign rec_count        = count_q;

endmodule

// File: tb/tb_record_sequencer.sv
// Directed bench for record_sequencer: MOVE flow, backpressure, STOP/resume,
// bad opcode, enable gating, mid-operation reset and (optionally) checksum errors.
module tb_record_sequencer;
    import record_pkg::*;

    localparam int WS = 8;
    localparam int RW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          resume;
    logic          halted;
    logic          error;
    logic [CW-1:0] rec_count;

    int vectors = 0;
    int fails   = 0;

    record_sequencer_if #(.WordSize(WS), .RecordWords(RW)) bus ();

    record_sequencer #(
        .WordSize    (WS),
        .RecordWords (RW),
        .CountWidth  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .resume    (resume),
        .bus       (bus.master),
        .halted    (halted),
        .error     (error),
        .rec_count (rec_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word 0 = opcode, word i = seed+i; last word fixed up as checksum when enabled.
    function automatic logic [127:0] mk(input logic [7:0] op, input logic [7:0] seed);
        logic [127:0] r;
        logic [7:0]   x;
        r[7:0] = op;
        for (int i = 1; i < RW; i++) r[i*8 +: 8] = seed + 8'(i);
`ifdef RECORD_CHECKSUM_EN
        x = '0;
        for (int i = 0; i < RW - 1; i++) x = x ^ r[i*8 +: 8];
        r[127:120] = x;
`else
        x = '0;
        r[7:0] = r[7:0] ^ x;
`endif
        return r;
    endfunction

    function automatic logic [127:0] pay(input logic [127:0] r);
        logic [127:0] p;
        p = '0;
        p[119:0] = r[127:8];
        return p;
    endfunction

    logic [127:0] rec_a, rec_b, rec_c, rec_d, rec_stop, rec_nop, rec_bad;

    initial begin
        rec_a    = mk(OP_MOVE, 8'h10);
        rec_b    = mk(OP_MOVE, 8'h40);
        rec_c    = mk(OP_MOVE, 8'h80);
        rec_d    = mk(OP_MOVE, 8'hC0);
        rec_stop = mk(OP_STOP, 8'h20);
        rec_nop  = mk(OP_NOP,  8'h30);
        rec_bad  = mk(8'h7F,   8'h50);

        rst = 1'b1; enable = 1'b1; resume = 1'b0;
        bus.fifo_empty = 1'b0; bus.fifo_data = rec_a; bus.seg_ready = 1'b0;

        // Reset
        tick();
        chk("rd_en_in_rst", 128'(bus.fifo_read_en), 128'd0);
        tick();
        chk("rst_valid", 128'(bus.seg_valid), 128'd0);
        chk("rst_data", pay(128'(bus.seg_data) << 8), 128'd0);
        chk("rst_halted", 128'(halted), 128'd0);
        chk("rst_error", 128'(error), 128'd0);
        chk("rst_count", 128'(rec_count), 128'd0);
        rst = 1'b0; bus.fifo_empty = 1'b1;
        tick();

        // MOVE flow, ready already high
        bus.fifo_empty = 1'b0; bus.fifo_data = rec_a; bus.seg_ready = 1'b1;
        settle();
        chk("mv_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_empty = 1'b1;
        settle();
        chk("mv_dec_rd_en", 128'(bus.fifo_read_en), 128'd0);
        chk("mv_dec_valid", 128'(bus.seg_valid), 128'd0);
        tick(); settle();
        chk("mv_valid", 128'(bus.seg_valid), 128'd1);
        chk("mv_data", 128'(bus.seg_data), pay(rec_a));
        tick(); settle();
        chk("mv_valid_drop", 128'(bus.seg_valid), 128'd0);
        chk("mv_count", 128'(rec_count), 128'd1);

        // Backpressure: ready low for 5 ISSUE cycles, another record waiting
        bus.seg_ready = 1'b0; bus.fifo_empty = 1'b0; bus.fifo_data = rec_b;
        settle();
        chk("bp_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_data = rec_c;
        settle();
        chk("bp_dec_rd_en", 128'(bus.fifo_read_en), 128'd0);
        for (int k = 0; k < 5; k++) begin
            tick(); settle();
            chk("bp_hold_valid", 128'(bus.seg_valid), 128'd1);
            chk("bp_hold_data", 128'(bus.seg_data), pay(rec_b));
            chk("bp_hold_rd_en", 128'(bus.fifo_read_en), 128'd0);
        end
        tick();
        bus.seg_ready = 1'b1;
        settle();
        chk("bp_last_valid", 128'(bus.seg_valid), 128'd1);
        chk("bp_last_data", 128'(bus.seg_data), pay(rec_b));
        chk("bp_count_before", 128'(rec_count), 128'd1);
        tick();
        bus.fifo_empty = 1'b1; bus.seg_ready = 1'b0;
        settle();
        chk("bp_valid_drop", 128'(bus.seg_valid), 128'd0);
        chk("bp_count", 128'(rec_count), 128'd2);

        // STOP then MOVE, resume in the entry cycle ignored
        bus.fifo_empty = 1'b0; bus.fifo_data = rec_stop;
        settle();
        chk("st_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_data = rec_c; resume = 1'b1;
        settle();
        tick();
        resume = 1'b0;
        settle();
        chk("st_halted", 128'(halted), 128'd1);
        chk("st_count", 128'(rec_count), 128'd3);
        for (int k = 0; k < 10; k++) begin
            tick(); settle();
            chk("st_no_read", 128'(bus.fifo_read_en), 128'd0);
            chk("st_still_halted", 128'(halted), 128'd1);
        end
        tick();
        resume = 1'b1;
        settle();
        chk("st_halted_at_resume", 128'(halted), 128'd1);
        tick();
        resume = 1'b0; bus.seg_ready = 1'b1;
        settle();
        chk("st_resumed", 128'(halted), 128'd0);
        chk("st_resume_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_empty = 1'b1;
        tick(); settle();
        chk("st_mv_valid", 128'(bus.seg_valid), 128'd1);
        chk("st_mv_data", 128'(bus.seg_data), pay(rec_c));
        tick(); settle();
        chk("st_mv_count", 128'(rec_count), 128'd4);

        // resume while IDLE is ignored
        resume = 1'b1;
        tick();
        resume = 1'b0;
        settle();
        chk("idle_resume_halted", 128'(halted), 128'd0);

        // Bad opcode then NOP
        bus.fifo_empty = 1'b0; bus.fifo_data = rec_bad;
        settle();
        chk("bad_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_data = rec_nop;
        tick(); settle();
        chk("bad_error", 128'(error), 128'd1);
        chk("bad_count", 128'(rec_count), 128'd4);
        chk("bad_valid", 128'(bus.seg_valid), 128'd0);
        chk("nop_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_empty = 1'b1;
        tick(); settle();
        chk("nop_count", 128'(rec_count), 128'd5);
        chk("error_sticky", 128'(error), 128'd1);

        // Enable gating, then reset during ISSUE
        enable = 1'b0; bus.fifo_empty = 1'b0; bus.fifo_data = rec_d; bus.seg_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("gate_rd_en", 128'(bus.fifo_read_en), 128'd0);
            tick();
        end
        enable = 1'b1;
        settle();
        chk("ungate_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_empty = 1'b1;
        tick(); settle();
        chk("rs_issue_valid", 128'(bus.seg_valid), 128'd1);
        rst = 1'b1;
        tick();
        chk("rs_valid", 128'(bus.seg_valid), 128'd0);
        chk("rs_data", 128'(bus.seg_data), 128'd0);
        chk("rs_halted", 128'(halted), 128'd0);
        chk("rs_error", 128'(error), 128'd0);
        chk("rs_count", 128'(rec_count), 128'd0);
        chk("rs_rd_en", 128'(bus.fifo_read_en), 128'd0);
        rst = 1'b0;
        tick();
        chk("rs_after_valid", 128'(bus.seg_valid), 128'd0);

`ifdef RECORD_CHECKSUM_EN
        // Checksum failure: one payload bit flipped
        bus.fifo_data = rec_a ^ (128'd1 << 20);
        bus.fifo_empty = 1'b0; bus.seg_ready = 1'b1;
        settle();
        chk("cs_rd_en", 128'(bus.fifo_read_en), 128'd1);
        tick();
        bus.fifo_empty = 1'b1;
        tick(); settle();
        chk("cs_error", 128'(error), 128'd1);
        chk("cs_valid", 128'(bus.seg_valid), 128'd0);
        chk("cs_count", 128'(rec_count), 128'd0);
        tick(); settle();
        chk("cs_valid_later", 128'(bus.seg_valid), 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/record_sequencer.md
# record_sequencer

Control block on the read side of the byte-to-record FIFO. Watches the FIFO's empty flag, dequeues one record at a time, and decodes its opcode byte. MOVE payloads go to the step-generation engine over a valid/ready handshake; NOP, STOP and malformed records are handled locally. Only this block asserts the FIFO read request, so every record is consumed exactly once and in order.

## Interface
Parameters:
- WordSize, 8, bits per FIFO word (byte)
- RecordWords, 16, words per record (power of 2, ≥ 2)
- CountWidth, 16, width of the executed-record counter

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  level; when low, no new record is fetched
- resume  input  1  one-cycle pulse; leaves HALTED
- fifo_empty  input  1  FIFO holds no complete record
- fifo_data  input  WordSize*RecordWords  record at FIFO head; word i at bits [(i+1)*WordSize-1 : i*WordSize]
- fifo_read_en  output  1  dequeue strobe to FIFO
- seg_valid  output  1  MOVE payload available
- seg_ready  input  1  downstream accepts payload
- seg_data  output  WordSize*(RecordWords-1)  record words 1..RecordWords-1
- halted  output  1  in HALTED state
- error  output  1  sticky; unknown opcode (or checksum fail)
- rec_count  output  CountWidth  records retired (MOVE accepted, NOP, STOP)

## Operation
- States: IDLE, DECODE, ISSUE, HALTED.
- IDLE: fifo_read_en = enable && !fifo_empty (combinational). In that cycle the block latches fifo_data into rec_r, then moves to DECODE.
- DECODE (one cycle): the opcode is word 0 of rec_r.
  - 0x00 NOP: rec_count+1, go to IDLE.
  - 0x01 MOVE: go to ISSUE.
  - 0x02 STOP: rec_count+1, go to HALTED.
  - Any other value: error <= 1, record discarded, rec_count unchanged, go to IDLE.
- ISSUE: seg_valid = 1 and seg_data = rec_r[top:WordSize], both held stable until seg_ready.
  - On handshake (seg_valid && seg_ready): rec_count+1, go to IDLE.
  - seg_valid never drops without a handshake.
- HALTED: halted = 1, no fetches. A resume pulse moves the block to IDLE. resume in any other state is ignored.
- enable is sampled only in IDLE. Deasserting it never aborts DECODE, ISSUE or HALTED.
- rec_count wraps modulo 2^CountWidth.
- error clears only on rst.

## Timing
- Reset values: state IDLE, fifo_read_en 0, seg_valid 0, seg_data 0, halted 0, error 0, rec_count 0, rec_r 0.
- While rst is high, fifo_read_en is forced to 0.
- fifo_data is valid only before the dequeue edge, so rec_r captures it on the same edge that fifo_read_en is high.
- MOVE latency: fifo_read_en in cycle N, DECODE in N+1, seg_valid high in N+2.
  - seg_ready already high in N+2 → handshake in N+2, IDLE in N+3, next fifo_read_en possible in N+3.
  - Minimum spacing is therefore 3 cycles per MOVE and 2 cycles per NOP.
- fifo_read_en is never asserted outside IDLE, so at most one record is in flight.
- resume arriving in the same cycle the block enters HALTED is ignored. It must arrive while halted = 1.
- A mid-operation rst returns the block to IDLE in the next cycle and discards any latched record without a handshake.

## Configuration
- RECORD_CHECKSUM_EN defined:
  - Word RecordWords-1 is a checksum; the XOR of all RecordWords words must equal 0.
  - On mismatch in DECODE: error <= 1, record discarded, rec_count unchanged, go to IDLE.
  - The checksum check takes precedence over the opcode.
  - seg_data width is unchanged; the checksum word is passed through.
- RECORD_CHECKSUM_EN undefined: no check is made, and all words are payload.

## Structure
- Shared package record_pkg holds:
  - opcode constants OP_NOP, OP_MOVE, OP_STOP
  - state enum seq_state_t
  - the default record geometry (WordSize, RecordWords)
- Sub-module record_decoder is purely combinational. It takes rec_r and returns is_nop, is_move, is_stop, is_bad, plus checksum_ok under RECORD_CHECKSUM_EN.
- The FSM, counter and handshake stay in record_sequencer.

## Test plan
- MOVE flow: enable=1, fifo_empty falls with record word0=0x01 and seg_ready=1 → one fifo_read_en pulse, seg_valid 2 cycles later, seg_data = words 1..15, rec_count=1.
- Backpressure: MOVE with seg_ready low for 5 cycles → seg_valid and seg_data stable for 6 cycles, no further fifo_read_en, then a single handshake.
- STOP/resume: records STOP then MOVE → halted=1, no read for 10 cycles despite fifo_empty=0; a resume pulse → MOVE fetched, rec_count=2.
- Bad opcode: word0=0x7F → error=1 (stays set), rec_count unchanged, next NOP retires normally.
- Gating and reset: enable=0 with a non-empty FIFO → fifo_read_en stays 0; rst asserted during ISSUE → next cycle all outputs at reset values.
- Checksum (RECORD_CHECKSUM_EN defined): MOVE with one payload bit flipped → error=1, seg_valid never asserted.
